bsg_idiv_iterative_scheduler: RTL and testbench

Shares one iterative divider between `num_req_p` requesters using round-robin arbitration. The block sits between the requesters and the divider's input/output handshakes. It keeps one operation in flight, records the requester ID, and returns each result tagged with that ID through a one-entry response buffer. The buffer frees the divider as soon as a result is produced, provided the previous response has drained.

---
 rtl/bsg_idiv_sched_pkg.sv | 14 +
 rtl/bsg_idiv_sched_rr_arb.sv | 36 +++
 rtl/bsg_idiv_iterative_scheduler.sv | 117 +++++++++++
 tb/tb_bsg_idiv_iterative_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_idiv_sched_pkg.sv
// Shared types for the iterative-divider scheduler.
// Holds the scheduler state enum and an ID-width helper.
package bsg_idiv_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int safe_clog2(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_idiv_sched_rr_arb.sv
// Combinational round-robin arbiter; priority starts after last_id_i.
// Ports: req_v_i, last_id_i in; one-hot grant_o and encoded grant_id_o out.
module bsg_idiv_sched_rr_arb
    import bsg_idiv_sched_pkg::*;
#(
    parameter int  num_req_p   = 4,
    localparam int id_width_lp = safe_clog2(num_req_p)
) (
    input  logic [num_req_p-1:0]   req_v_i,
    input  logic [id_width_lp-1:0] last_id_i,
    output logic [num_req_p-1:0]   grant_o,
    output logic [id_width_lp-1:0] grant_id_o
);

    always_comb begin
        int                     idx;
        logic [id_width_lp-1:0] idx_w;
        logic                   found;
        grant_o    = '0;
        grant_id_o = '0;
        found      = 1'b0;
        idx        = 0;
        idx_w      = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            idx = int'(last_id_i) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            idx_w = id_width_lp'(idx);
            if (!found && req_v_i[idx_w]) begin
                found          = 1'b1;
                grant_o[idx_w] = 1'b1;
                grant_id_o     = idx_w;
            end
        end
    end

endmodule

// File: rtl/bsg_idiv_iterative_scheduler.sv
// Shares one iterative divider among num_req_p requesters (round-robin),
// one op in flight, result returned tagged with its ID via a 1-entry buffer.
// Ports: req_* (flattened per requester), div_* (divider side), resp_* (out).
module bsg_idiv_iterative_scheduler
    import bsg_idiv_sched_pkg::*;
#(
    parameter int  width_p     = 32,
    parameter int  num_req_p   = 4,
    localparam int id_width_lp = safe_clog2(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           req_v_i,
    output logic [num_req_p-1:0]           req_ready_and_o,
    input  logic [num_req_p*width_p-1:0]   req_dividend_i,
    input  logic [num_req_p*width_p-1:0]   req_divisor_i,
    input  logic [num_req_p-1:0]           req_signed_i,
    output logic                           div_v_o,
    input  logic                           div_ready_and_i,
    output logic [width_p-1:0]             div_dividend_o,
    output logic [width_p-1:0]             div_divisor_o,
    output logic                           div_signed_o,
    input  logic                           div_v_i,
    input  logic [width_p-1:0]             div_quotient_i,
    input  logic [width_p-1:0]             div_remainder_i,
    output logic                           div_yumi_o,
    output logic                           resp_v_o,
    output logic [id_width_lp-1:0]         resp_id_o,
    output logic [width_p-1:0]             resp_quotient_o,
    output logic [width_p-1:0]             resp_remainder_o,
    input  logic                           resp_yumi_i
);

    state_e                 state_r;
    logic [id_width_lp-1:0] last_id_r;
    logic [id_width_lp-1:0] inflight_id_r;
    logic                   resp_v_r;
    logic [id_width_lp-1:0] resp_id_r;
    logic [width_p-1:0]     resp_q_r;
    logic [width_p-1:0]     resp_r_r;

    logic [num_req_p-1:0]   grant;
    logic [id_width_lp-1:0] grant_id;
    logic                   idle;
    logic                   issue;

    bsg_idiv_sched_rr_arb #(
        .num_req_p(num_req_p)
    ) arb (
        .req_v_i   (req_v_i),
        .last_id_i (last_id_r),
        .grant_o   (grant),
        .grant_id_o(grant_id)
    );

    // Reset gates the handshakes combinationally so nothing issues or
    // retires while the system is held in reset.
    assign idle            = reset_n_i & (state_r == IDLE);
    assign div_v_o         = idle & (|req_v_i);
    assign req_ready_and_o = (idle & div_ready_and_i) ? grant : '0;
    assign issue           = |(req_v_i & req_ready_and_o);
    assign div_yumi_o      = reset_n_i & (state_r == BUSY) & div_v_i
                           & (~resp_v_r | resp_yumi_i);

    always_comb begin
        div_dividend_o = '0;
        div_divisor_o  = '0;
        div_signed_o   = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            div_dividend_o |= req_dividend_i[i*width_p +: width_p]
                            & {width_p{grant[i]}};
            div_divisor_o  |= req_divisor_i[i*width_p +: width_p]
                            & {width_p{grant[i]}};
            div_signed_o   |= req_signed_i[i] & grant[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r       <= IDLE;
            last_id_r     <= id_width_lp'(num_req_p - 1);
            inflight_id_r <= '0;
            resp_v_r      <= 1'b0;
            resp_id_r     <= '0;
            resp_q_r      <= '0;
            resp_r_r      <= '0;
        end else begin
            if (resp_yumi_i) resp_v_r <= 1'b0;
            // A load in the same cycle as a drain wins.
            if (div_yumi_o) begin
                resp_v_r  <= 1'b1;
                resp_id_r <= inflight_id_r;
                resp_q_r  <= div_quotient_i;
                resp_r_r  <= div_remainder_i;
            end
            unique case (state_r)
                IDLE: begin
                    if (issue) begin
                        inflight_id_r <= grant_id;
                        last_id_r     <= grant_id;
                        state_r       <= BUSY;
                    end
                end
                BUSY: begin
                    if (div_yumi_o) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign resp_v_o         = resp_v_r;
    assign resp_id_o        = resp_id_r;
    assign resp_quotient_o  = resp_q_r;
    assign resp_remainder_o = resp_r_r;

endmodule

// File: tb/tb_bsg_idiv_iterative_scheduler.sv
// Self-checking bench for bsg_idiv_iterative_scheduler with a divider model
// and a transaction-level reference model of arbitration and buffering.
module tb_bsg_idiv_iterative_scheduler;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req_v;
    logic [3:0]   req_ready;
    logic [31:0]  dvd [4];
    logic [31:0]  dvs [4];
    logic [3:0]   sgn;
    logic [127:0] dvd_flat;
    logic [127:0] dvs_flat;
    logic         div_v_o;
    logic         div_ready;
    logic [31:0]  div_dividend;
    logic [31:0]  div_divisor;
    logic         div_signed;
    logic         div_v_in;
    logic [31:0]  div_q;
    logic [31:0]  div_r;
    logic         div_yumi;
    logic         resp_v;
    logic [1:0]   resp_id;
    logic [31:0]  resp_q;
    logic [31:0]  resp_r;
    logic         resp_yumi;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dvd_flat[i*32 +: 32] = dvd[i];
            dvs_flat[i*32 +: 32] = dvs[i];
        end
    end

    bsg_idiv_iterative_scheduler #(
        .width_p  (32),
        .num_req_p(4)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_v_i         (req_v),
        .req_ready_and_o (req_ready),
        .req_dividend_i  (dvd_flat),
        .req_divisor_i   (dvs_flat),
        .req_signed_i    (sgn),
        .div_v_o         (div_v_o),
        .div_ready_and_i (div_ready),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_signed_o    (div_signed),
        .div_v_i         (div_v_in),
        .div_quotient_i  (div_q),
        .div_remainder_i (div_r),
        .div_yumi_o      (div_yumi),
        .resp_v_o        (resp_v),
        .resp_id_o       (resp_id),
        .resp_quotient_o (resp_q),
        .resp_remainder_o(resp_r),
        .resp_yumi_i     (resp_yumi)
    );

    function automatic logic [63:0] ref_div(logic [31:0] a, logic [31:0] b,
                                            logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Environment: iterative divider with programmable latency.
    logic dv_busy;
    int   dv_cnt;
    int   dv_lat = 2;
    assign div_ready = ~dv_busy;

    always @(posedge clk) begin
        if (!reset_n) begin
            dv_busy  <= 1'b0;
            div_v_in <= 1'b0;
            dv_cnt   <= 0;
            div_q    <= '0;
            div_r    <= '0;
        end else if (!dv_busy) begin
            if (div_v_o && div_ready) begin
                {div_q, div_r} <= ref_div(div_dividend, div_divisor,
                                          div_signed);
                dv_busy <= 1'b1;
                dv_cnt  <= dv_lat;
            end
        end else if (div_v_in) begin
            if (div_yumi) begin
                div_v_in <= 1'b0;
                dv_busy  <= 1'b0;
            end
        end else if (dv_cnt == 0) begin
            div_v_in <= 1'b1;
        end else begin
            dv_cnt <= dv_cnt - 1;
        end
    end

    // Reference model state.
    bit          m_busy;
    bit          m_rv;
    int          m_last;
    int          m_inflight;
    logic [31:0] m_a, m_b;
    logic        m_s;
    int          m_rid;
    logic [31:0] m_rq, m_rr;
    logic [3:0]  acc;
    int          glog[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_op(int i);
        dvd[i] = $urandom;
        dvs[i] = $urandom_range(2, 1000);
        sgn[i] = $urandom_range(0, 1);
        if (sgn[i] && $urandom_range(0, 1) == 1) dvs[i] = -dvs[i];
    endtask

    // One cycle: entered at posedge+1 with inputs set, leaves at posedge+1.
    task automatic step();
        logic [3:0]  eg;
        int          g;
        logic        ey;
        logic [63:0] qr;
        #4;
        eg = '0;
        g  = -1;
        if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (m_last + k) % 4;
                if (g < 0 && req_v[c]) g = c;
            end
        end
        if (g >= 0 && div_ready) eg[g] = 1'b1;
        chk("grant", req_ready, eg);
        chk("div_v", div_v_o, g >= 0);
        if (g >= 0) begin
            chk("div_dividend", div_dividend, dvd[g]);
            chk("div_divisor", div_divisor, dvs[g]);
            chk("div_signed", div_signed, sgn[g]);
        end
        ey = m_busy && div_v_in && (!m_rv || resp_yumi);
        chk("div_yumi", div_yumi, ey);
        chk("resp_v", resp_v, m_rv);
        if (m_rv) begin
            chk("resp_id", resp_id, m_rid);
            chk("resp_q", resp_q, m_rq);
            chk("resp_r", resp_r, m_rr);
        end
        @(posedge clk);
        acc = '0;
        if (m_rv && resp_yumi) m_rv = 0;
        if (ey) begin
            qr     = ref_div(m_a, m_b, m_s);
            m_rv   = 1;
            m_rid  = m_inflight;
            m_rq   = qr[63:32];
            m_rr   = qr[31:0];
            m_busy = 0;
        end else if (eg != 0 && req_v[g]) begin
            m_busy     = 1;
            m_inflight = g;
            m_last     = g;
            m_a        = dvd[g];
            m_b        = dvs[g];
            m_s        = sgn[g];
            acc[g]     = 1'b1;
            glog.push_back(g);
        end
        #1;
    endtask

    task automatic do_reset(int n);
        reset_n = 1'b0;
        repeat (n) begin
            #4;
            chk("rst_ready", req_ready, 4'b0);
            chk("rst_div_v", div_v_o, 1'b0);
            chk("rst_yumi", div_yumi, 1'b0);
            @(posedge clk);
            #1;
        end
        m_busy = 0;
        m_rv   = 0;
        m_last = 3;
        chk("rst_resp_v", resp_v, 1'b0);
        chk("rst_resp_id", resp_id, 2'd0);
        chk("rst_resp_q", resp_q, 32'd0);
        chk("rst_resp_r", resp_r, 32'd0);
        reset_n = 1'b1;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 50 && !m_rv; i++) step();
        chk("wait_resp", resp_v, 1'b1);
    endtask

    task automatic drain();
        req_v = '0;
        for (int i = 0; i < 60 && (m_busy || m_rv); i++) begin
            resp_yumi = m_rv;
            step();
        end
        resp_yumi = 1'b0;
        chk("drain", resp_v, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_v     = 4'b1111;
        resp_yumi = 1'b0;
        sgn       = '0;
        for (int i = 0; i < 4; i++) new_op(i);
        do_reset(2);

        // Single op from requester 0.
        req_v  = 4'b0001;
        dvd[0] = 32'd100;
        dvs[0] = 32'd7;
        sgn[0] = 1'b0;
        step();
        chk("single_acc", acc, 4'b0001);
        req_v = '0;
        wait_resp();
        chk("single_id", resp_id, 2'd0);
        chk("single_q", resp_q, 32'd14);
        chk("single_r", resp_r, 32'd2);
        drain();

        // Fairness: all requesters stay valid.
        do_reset(1);
        glog.delete();
        req_v = 4'b1111;
        for (int i = 0; i < 4; i++) new_op(i);
        for (int i = 0; i < 200 && glog.size() < 6; i++) begin
            resp_yumi = m_rv;
            for (int j = 0; j < 4; j++) if (acc[j]) new_op(j);
            step();
        end
        chk("fair_count", glog.size(), 6);
        begin
            int exp_order [6] = '{0, 1, 2, 3, 0, 1};
            for (int k = 0; k < 6 && k < glog.size(); k++)
                chk("fair_order", glog[k], exp_order[k]);
        end
        drain();

        // Rotation skip: last grant was 1, only 0 and 3 request.
        glog.delete();
        req_v = 4'b1001;
        for (int i = 0; i < 100 && glog.size() < 2; i++) begin
            resp_yumi = m_rv;
            for (int j = 0; j < 4; j++) if (acc[j]) new_op(j);
            step();
        end
        chk("skip_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("skip_first", glog[0], 3);
            chk("skip_second", glog[1], 0);
        end
        drain();

        // Backpressure: buffer full, second result held until yumi.
        resp_yumi = 1'b0;
        req_v     = 4'b0001;
        dvd[0]    = 32'd100;
        dvs[0]    = 32'd7;
        sgn[0]    = 1'b0;
        step();
        req_v = '0;
        wait_resp();
        req_v  = 4'b0010;
        dvd[1] = 32'd100;
        dvs[1] = 32'd3;
        sgn[1] = 1'b0;
        step();
        chk("bp_issue", acc, 4'b0010);
        req_v = '0;
        for (int i = 0; i < 30 && !div_v_in; i++) step();
        chk("bp_div_v", div_v_in, 1'b1);
        step();
        step();
        chk("bp_hold_q", resp_q, 32'd14);
        chk("bp_hold_id", resp_id, 2'd0);
        resp_yumi = 1'b1;
        #4;
        chk("bp_yumi_now", div_yumi, 1'b1);
        #1;
        @(posedge clk);
        #1;
        m_rv   = 1;
        m_rid  = 1;
        m_rq   = 32'd33;
        m_rr   = 32'd1;
        m_busy = 0;
        resp_yumi = 1'b0;
        chk("bp_new_v", resp_v, 1'b1);
        chk("bp_new_id", resp_id, 2'd1);
        chk("bp_new_q", resp_q, 32'd33);
        chk("bp_new_r", resp_r, 32'd1);
        drain();

        // Signed passthrough from requester 2.
        req_v  = 4'b0100;
        dvd[2] = -32'sd7;
        dvs[2] = 32'd2;
        sgn[2] = 1'b1;
        step();
        chk("sgn_acc", acc, 4'b0100);
        req_v = '0;
        wait_resp();
        chk("sgn_id", resp_id, 2'd2);
        chk("sgn_q", resp_q, 32'hFFFF_FFFD);
        chk("sgn_r", resp_r, 32'hFFFF_FFFF);
        drain();

        // Reset while busy abandons the op.
        dv_lat = 6;
        req_v  = 4'b0100;
        step();
        req_v = '0;
        step();
        chk("mid_busy", div_v_o, 1'b0);
        do_reset(1);
        glog.delete();
        req_v = 4'b1111;
        for (int i = 0; i < 4; i++) new_op(i);
        step();
        chk("mid_first", glog.size() > 0 ? glog[0] : -1, 0);
        req_v = '0;
        drain();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (acc[j]) req_v[j] = 1'b0;
                if (!req_v[j] && $urandom_range(0, 2) == 0) begin
                    new_op(j);
                    req_v[j] = 1'b1;
                end
            end
            resp_yumi = m_rv ? 1'($urandom_range(0, 1)) : 1'b0;
            dv_lat    = $urandom_range(0, 4);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
